// File: rtl/div_share_pkg.sv
// Shared types and constants for the shared-divider controller.
// Field widths in div_resp_t are maxima; narrower configurations zero-extend into them.
package div_share_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } div_state_e;

  localparam int unsigned MaxWidth = 64;
  localparam int unsigned MaxIdw   = 3;

  localparam logic [MaxWidth-1:0] DIV0_QUOTIENT = '1;

  typedef struct packed {
    logic [MaxIdw-1:0]   id;
    logic [MaxWidth-1:0] quotient;
    logic [MaxWidth-1:0] remainder;
    logic                div0;
  } div_resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr_i, wrapping.
// Produces a one-hot grant and its index; no request means an all-zero grant.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o
);

  logic        found;
  int unsigned k;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    k         = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = 32'(ptr_i) + i;
      if (k >= NREQ) begin
        k = k - NREQ;
      end
      if (!found && req_i[IDW'(k)]) begin
        found              = 1'b1;
        gnt_o[IDW'(k)]     = 1'b1;
        gnt_idx_o          = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one iterative signed divider among NREQ round-robin requesters.
// Optional: define DIV_SHARE_ZERO_BYPASS_EN to answer zero-divisor operations without the divider.
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_quotient,
  output logic [WIDTH-1:0]      resp_remainder,
  output logic                  resp_div0,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divisor,
  input  logic                  div_ready,
  input  logic [WIDTH-1:0]      div_quotient,
  input  logic [WIDTH-1:0]      div_remainder
);

  div_state_e       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             div0_q, div0_d;
  logic             wait_first_q, wait_first_d;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];
  logic [WIDTH-1:0] sel_dividend, sel_divisor;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_a[g] = req_dividend[g*WIDTH +: WIDTH];
    assign op_b[g] = req_divisor[g*WIDTH +: WIDTH];
  end

  assign sel_dividend = op_a[gnt_idx];
  assign sel_divisor  = op_b[gnt_idx];

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    div0_d       = div0_q;
    wait_first_d = 1'b0;
    req_ready    = '0;
    div_start    = 1'b0;
    resp_valid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = gnt;
        if (|req_valid) begin
          ptr_d      = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
          id_d       = gnt_idx;
          dividend_d = sel_dividend;
          divisor_d  = sel_divisor;
          div0_d     = (sel_divisor == '0);
`ifdef DIV_SHARE_ZERO_BYPASS_EN
          if (sel_divisor == '0) begin
            quot_d  = DIV0_QUOTIENT[WIDTH-1:0];
            rem_d   = sel_dividend;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
`else
          state_d = StIssue;
`endif
        end
      end
      StIssue: begin
        div_start    = 1'b1;
        wait_first_d = 1'b1;
        state_d      = StWait;
      end
      StWait: begin
        // The divider still shows the previous ready level in the first WAIT cycle.
        if (!wait_first_q && div_ready) begin
          quot_d  = div_quotient;
          rem_d   = div_remainder;
          state_d = StResp;
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      id_q         <= '0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      div0_q       <= 1'b0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
      div0_q       <= div0_d;
      wait_first_q <= wait_first_d;
    end
  end

  assign div_dividend   = dividend_q;
  assign div_divisor    = divisor_q;
  assign resp_id        = id_q;
  assign resp_quotient  = quot_q;
  assign resp_remainder = rem_q;
  assign resp_div0      = div0_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl with a behavioural multi-cycle divider model.
module tb_div_share_ctrl;
  import div_share_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 32;
  localparam int unsigned IW  = 2;
  localparam int unsigned LAT = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_dividend, req_divisor;
  logic           resp_valid, resp_ready;
  logic [IW-1:0]  resp_id;
  logic [W-1:0]   resp_quotient, resp_remainder;
  logic           resp_div0;
  logic           div_start;
  logic [W-1:0]   div_dividend, div_divisor;
  logic           div_ready;
  logic [W-1:0]   div_quotient, div_remainder;

  logic [W-1:0]   a_arr [N];
  logic [W-1:0]   b_arr [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_dividend[g*W +: W] = a_arr[g];
    assign req_divisor[g*W +: W]  = b_arr[g];
  end

  div_share_ctrl #(
    .NREQ  (N),
    .WIDTH (W),
    .IDW   (IW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dividend   (req_dividend),
    .req_divisor    (req_divisor),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_id        (resp_id),
    .resp_quotient  (resp_quotient),
    .resp_remainder (resp_remainder),
    .resp_div0      (resp_div0),
    .div_start      (div_start),
    .div_dividend   (div_dividend),
    .div_divisor    (div_divisor),
    .div_ready      (div_ready),
    .div_quotient   (div_quotient),
    .div_remainder  (div_remainder)
  );

  // Divider model: ready stays high one cycle after start, then low for LAT cycles.
  logic [W-1:0] m_a, m_b;
  logic         m_arm;
  int unsigned  m_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      div_ready     <= 1'b1;
      div_quotient  <= '0;
      div_remainder <= '0;
      m_a           <= '0;
      m_b           <= '0;
      m_arm         <= 1'b0;
      m_cnt         <= 0;
    end else begin
      if (div_start) begin
        m_arm <= 1'b1;
        m_a   <= div_dividend;
        m_b   <= div_divisor;
      end
      if (m_arm) begin
        m_arm     <= 1'b0;
        div_ready <= 1'b0;
        m_cnt     <= LAT;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          div_ready <= 1'b1;
          if (m_b == '0) begin
            div_quotient  <= 32'hA5A5_0000;
            div_remainder <= 32'h0000_5A5A;
          end else begin
            div_quotient  <= $signed(m_a) / $signed(m_b);
            div_remainder <= $signed(m_a) % $signed(m_b);
          end
        end
      end
    end
  end

  typedef struct packed {
    div_resp_t  r;
    logic [7:0] starts;
  } exp_t;

  exp_t          sb_q [$];
  logic [IW-1:0] gnt_q [$];
  int            tests = 0;
  int            fails = 0;
  int            timeouts = 0;
  logic          chk_zero = 1'b0;
  logic          quiet = 1'b0;
  logic          exp_resp_now = 1'b0;
  logic          chk_final = 1'b0;
  logic          final_done = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push_exp(logic [IW-1:0] id, logic [W-1:0] q, logic [W-1:0] r,
                                   logic d0, int st);
    exp_t e;
    e.r.id        = 3'(id);
    e.r.quotient  = 64'(q);
    e.r.remainder = 64'(r);
    e.r.div0      = d0;
    e.starts      = 8'(st);
    sb_q.push_back(e);
  endfunction

  initial begin : monitor
    logic          pv, pr, pd0;
    logic [IW-1:0] pid, g;
    logic [W-1:0]  pq, prm;
    int            starts, tseen;
    exp_t          e;
    pv = 1'b0; pr = 1'b0; pd0 = 1'b0; pid = '0; pq = '0; prm = '0; g = '0;
    starts = 0; tseen = 0;
    forever begin
      @(negedge clk);
      if (chk_zero) begin
        chk("zero_req_ready", 64'(req_ready), 64'd0);
        chk("zero_resp_ctl", 64'({resp_valid, resp_div0, div_start, resp_id}), 64'd0);
        chk("zero_resp_q", 64'(resp_quotient), 64'd0);
        chk("zero_resp_r", 64'(resp_remainder), 64'd0);
        chk("zero_div_ops", {div_dividend, div_divisor}, 64'd0);
      end
      if (timeouts != tseen) begin
        chk("wait_bound", 64'(timeouts), 64'(tseen));
        tseen = timeouts;
      end
      if (reset) begin
        starts = 0;
        pv     = 1'b0;
      end else begin
        if (div_start) starts++;
        if (quiet) begin
          chk("bp_req_ready", 64'(req_ready), 64'd0);
          chk("bp_div_start", 64'(div_start), 64'd0);
        end
        if (exp_resp_now) chk("bypass_latency", 64'(resp_valid), 64'd1);
        if (|req_ready) begin
          chk("req_ready_onehot", 64'($onehot(req_ready)), 64'd1);
          if (gnt_q.size() == 0) begin
            chk("unexpected_grant", 64'(req_ready), 64'd0);
          end else begin
            g = gnt_q.pop_front();
            chk("grant_order", 64'(req_ready), 64'(4'b0001 << g));
          end
        end
        if (pv && !pr) begin
          chk("hold_valid", 64'(resp_valid), 64'd1);
          chk("hold_id", 64'(resp_id), 64'(pid));
          chk("hold_quot", 64'(resp_quotient), 64'(pq));
          chk("hold_rem", 64'(resp_remainder), 64'(prm));
          chk("hold_div0", 64'(resp_div0), 64'(pd0));
        end
        if (resp_valid && resp_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_resp", 64'(resp_valid), 64'd0);
          end else begin
            e = sb_q.pop_front();
            chk("resp_id", 64'(resp_id), 64'(e.r.id));
            chk("resp_quot", 64'(resp_quotient), e.r.quotient);
            chk("resp_rem", 64'(resp_remainder), e.r.remainder);
            chk("resp_div0", 64'(resp_div0), 64'(e.r.div0));
            chk("div_start_count", 64'(starts), 64'(e.starts));
          end
          starts = 0;
        end
        pv = resp_valid; pr = resp_ready; pid = resp_id;
        pq = resp_quotient; prm = resp_remainder; pd0 = resp_div0;
      end
      if (chk_final) begin
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        chk("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
        final_done = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [IW-1:0] i, logic [W-1:0] a, logic [W-1:0] b);
    a_arr[i]     = a;
    b_arr[i]     = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(logic [IW-1:0] i);
    int n = 0;
    #1;
    while (!req_ready[i] && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready[i]) timeouts++;
  endtask

  task automatic wait_resp(int hold);
    int n = 0;
    while (!resp_valid && n < 100) begin
      tick();
      n++;
    end
    if (!resp_valid) timeouts++;
    quiet = (hold > 0);
    repeat (hold) tick();
    quiet      = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  logic [W-1:0] eq [N];
  logic [W-1:0] er [N];

  initial begin : stim
    logic [IW-1:0] g;
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    a_arr      = '{default: '0};
    b_arr      = '{default: '0};
    eq = '{32'd6, 32'hFFFF_FFF8, 32'hFFFF_FFF1, 32'd2};
    er = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF};

    repeat (2) tick();
    chk_zero = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk_zero = 1'b0;

    // 100 / 7 from requester 1, held 5 cycles
    gnt_q.push_back(2'd1);
    push_exp(2'd1, 32'd14, 32'd2, 1'b0, 1);
    drive(2'd1, 32'd100, 32'd7);
    wait_grant(2'd1);
    tick();
    req_valid[1] = 1'b0;
    wait_resp(5);

    // -100 / 7
    gnt_q.push_back(2'd1);
    push_exp(2'd1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1);
    drive(2'd1, 32'hFFFF_FF9C, 32'd7);
    wait_grant(2'd1);
    tick();
    req_valid[1] = 1'b0;
    wait_resp(0);

    // 55 / 0 from requester 2
    gnt_q.push_back(2'd2);
`ifdef DIV_SHARE_ZERO_BYPASS_EN
    push_exp(2'd2, 32'hFFFF_FFFF, 32'd55, 1'b1, 0);
`else
    push_exp(2'd2, 32'hA5A5_0000, 32'h0000_5A5A, 1'b1, 1);
`endif
    drive(2'd2, 32'd55, 32'd0);
    wait_grant(2'd2);
    tick();
    req_valid[2] = 1'b0;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
    exp_resp_now = 1'b1;
    @(negedge clk);
    #1;
    exp_resp_now = 1'b0;
`endif
    wait_resp(2);

    // All four continuously valid from pointer 0; first response back-pressured 20 cycles
    do_reset();
    drive(2'd0, 32'd20, 32'd3);
    drive(2'd1, 32'hFFFF_FFCE, 32'd6);
    drive(2'd2, 32'd77, 32'hFFFF_FFFB);
    drive(2'd3, 32'hFFFF_FFF7, 32'hFFFF_FFFC);
    g = '0;
    for (int k = 0; k < 5; k++) begin
      gnt_q.push_back(g);
      push_exp(g, eq[g], er[g], 1'b0, 1);
      wait_grant(g);
      tick();
      if (k == 4) req_valid = '0;
      wait_resp(k == 0 ? 20 : 1);
      g = g + 2'd1;
    end

    // Reset three cycles after div_start aborts the operation silently
    gnt_q.push_back(2'd2);
    drive(2'd2, 32'd9, 32'd2);
    wait_grant(2'd2);
    tick();
    req_valid[2] = 1'b0;
    repeat (3) tick();
    reset    = 1'b1;
    chk_zero = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk_zero   = 1'b0;
    resp_ready = 1'b1;
    repeat (20) tick();
    resp_ready = 1'b0;

    // Pointer restarted at 0: requester 1 wins over 3
    gnt_q.push_back(2'd1);
    gnt_q.push_back(2'd3);
    push_exp(2'd1, 32'd14, 32'd2, 1'b0, 1);
    push_exp(2'd3, 32'd0, 32'd7, 1'b0, 1);
    drive(2'd1, 32'd100, 32'd7);
    drive(2'd3, 32'd7, 32'hFFFF_FF9C);
    wait_grant(2'd1);
    tick();
    req_valid[1] = 1'b0;
    wait_resp(0);
    wait_grant(2'd3);
    tick();
    req_valid[3] = 1'b0;
    wait_resp(0);

    repeat (3) tick();
    chk_final = 1'b1;
    for (int n = 0; n < 10 && !final_done; n++) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Shares one iterative signed divider among NREQ requesters, each with its own valid/ready request port.
- Arbitrates round-robin and owns the divider's start/ready sequencing.
- Captures quotient and remainder into a held response, tagged with the requester ID.
- Sits between the integer-execution clients and the single shared SRT-style divider instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 32, operand and result width.
- IDW, 2, requester ID width; equals clog2(NREQ), minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_dividend  in  NREQ*WIDTH  signed dividends, packed; requester i occupies bits [i*WIDTH +: WIDTH].
- req_divisor  in  NREQ*WIDTH  signed divisors, packed the same way.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  IDW  requester that issued the operation.
- resp_quotient  out  WIDTH  signed quotient.
- resp_remainder  out  WIDTH  signed remainder.
- resp_div0  out  1  divisor was zero.
- div_start  out  1  one-cycle start pulse to the divider.
- div_dividend  out  WIDTH  registered operand to the divider.
- div_divisor  out  WIDTH  registered operand to the divider.
- div_ready  in  1  divider idle/complete (level).
- div_quotient  in  WIDTH  divider result.
- div_remainder  in  WIDTH  divider result.

Behaviour:
- Reset values: every output 0, FSM in IDLE, round-robin pointer 0, response registers 0. Reset mid-operation aborts it with no response; the divider is reset by its own reset.

State machine:
- IDLE: req_ready is combinational. It is high only for the granted requester g, where g is the first asserted req_valid at or after the pointer, wrapping around.
  - On grant, latch operands and ID, set pointer to (g+1) mod NREQ, go to ISSUE.
  - No req_valid means no grant.
- ISSUE: assert div_start for exactly 1 cycle, go to WAIT.
- WAIT: ignore div_ready in the first WAIT cycle (the divider drops ready one cycle after start). Afterwards, on div_ready=1, capture div_quotient and div_remainder and go to RESP.
- RESP: resp_valid=1, with all response fields held stable until resp_ready=1.
  - On that handshake cycle, go to IDLE.
  - No new grant in the handshake cycle, so the minimum spacing between accepts is 4 cycles plus the divider latency.

Rules:
- Only one operation is outstanding; req_ready is 0 in every state except IDLE.
- Fairness: a continuously asserted requester is granted within NREQ grants.
- Requesters must hold operands stable while req_valid=1 and req_ready=0. Operands are sampled only on the grant cycle.
- div_ready staying low indefinitely leaves the block in WAIT. No timeout in the base block.
- resp_div0 = (latched divisor == 0), always computed.
- Simultaneous events:
  - req_valid rising during RESP waits for IDLE.
  - resp_ready high outside RESP is ignored.
  - All NREQ requesting at once are served in rotation starting at the pointer.

Optional Feature:
- Macro: DIV_SHARE_ZERO_BYPASS_EN.
- When defined: a granted operation with divisor 0 skips ISSUE/WAIT and goes directly to RESP the next cycle. div_start is never pulsed. Response is quotient = all ones (-1), remainder = latched dividend, resp_div0=1.
- When undefined: zero divisors go through the divider like any other operation, its results are passed through unchanged, and resp_div0 still flags the case.

Decomposition:
- Package div_share_pkg holds:
  - the FSM state typedef (IDLE, ISSUE, WAIT, RESP);
  - the constant DIV0_QUOTIENT = all ones;
  - the response struct (id, quotient, remainder, div0).
- One natural sub-module, rr_arbiter: parameterised by NREQ, takes req vector and pointer, produces a one-hot grant and the grant index. It is reused by other shared-resource controllers.

Test Plan:
- Single op: requester 1 sends 100 / 7 -> req_ready[1] for one cycle, one div_start pulse, response quotient 14, remainder 2, id 1, div0 0. Response held while resp_ready=0 for 5 cycles.
- Negative operands: -100 / 7 -> quotient -14, remainder -2, matching the divider output passed through unchanged.
- All 4 requesters valid continuously with pointer 0 -> grant order 0,1,2,3,0. No requester starves. Exactly one req_ready bit high per grant.
- Back-pressure: resp_ready=0 for 20 cycles with other requests pending -> no req_ready, no div_start, response fields stable.
- Divide by zero: requester 2 sends 55 / 0.
  - With DIV_SHARE_ZERO_BYPASS_EN: no div_start, RESP one cycle after grant, quotient 0xFFFFFFFF, remainder 55, div0 1.
  - Without it: div0 1 and the divider's results are passed through unchanged.
- Reset in WAIT: assert reset 3 cycles after div_start -> all outputs 0 immediately, no response ever issued, next request served normally starting with pointer 0.
